// File: rtl/segment_id_ex_param.sv
// rtl/segment_id_ex_param.sv - parametrised ID/EX pipeline register with stall, flush, valid and optional perf counters
//
// Purpose: captures decode-stage control and vector operands on the falling edge
// of clk and presents them to execute. Adds hold (StallE), bubble insertion
// (FlushE), a valid bit, and optional saturating stall/bubble counters.
//
// Ports:
//   clk, reset_n                 falling-edge clock, asynchronous active-low reset
//   StallE, FlushE               hold / bubble (flush wins over stall)
//   ValidD                       decode slot holds a real instruction
//   RegWriteD..ExtImmD           decode control and operands
//   ValidE, RegWriteE..ExtImmE   registered execute-side copies
//   PerfClr, StallCnt, BubbleCnt counter clear and counters (SEGMENT_ID_EX_PERF_EN only)
//
// Macro: SEGMENT_ID_EX_PERF_EN enables the performance counters.
module segment_id_ex_param #(
    parameter int LANES     = 6,
    parameter int LANE_W    = 8,
    parameter int ALUCTRL_W = 3,
    parameter int REGADDR_W = 4,
    parameter int IDX_W     = 4,
    parameter int IMM_W     = 8,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    StallE,
    input  logic                    FlushE,
    input  logic                    ValidD,
    input  logic                    RegWriteD,
    input  logic                    MemtoRegD,
    input  logic                    MemWriteD,
    input  logic                    ALUSrcD,
    input  logic                    FlagsWriteD,
    input  logic [ALUCTRL_W-1:0]    ALUControlD,
    input  logic [REGADDR_W-1:0]    WA3D,
    input  logic [LANES*LANE_W-1:0] rd1D,
    input  logic [LANES*LANE_W-1:0] rd2D,
    input  logic [IDX_W-1:0]        rd2iD,
    input  logic [IMM_W-1:0]        ExtImmD,
    output logic                    ValidE,
    output logic                    RegWriteE,
    output logic                    MemtoRegE,
    output logic                    MemWriteE,
    output logic                    ALUSrcE,
    output logic                    FlagsWriteE,
    output logic [ALUCTRL_W-1:0]    ALUControlE,
    output logic [REGADDR_W-1:0]    WA3E,
    output logic [LANES*LANE_W-1:0] rd1E,
    output logic [LANES*LANE_W-1:0] rd2E,
    output logic [IDX_W-1:0]        rd2iE,
    output logic [IMM_W-1:0]        ExtImmE
`ifdef SEGMENT_ID_EX_PERF_EN
    ,
    input  logic                    PerfClr,
    output logic [CNT_W-1:0]        StallCnt,
    output logic [CNT_W-1:0]        BubbleCnt
`endif
);

    localparam int VEC_W = LANES * LANE_W;

    logic                 r_valid;
    logic                 r_reg_write;
    logic                 r_mem_to_reg;
    logic                 r_mem_write;
    logic                 r_alu_src;
    logic                 r_flags_write;
    logic [ALUCTRL_W-1:0] r_alu_control;
    logic [REGADDR_W-1:0] r_wa3;
    logic [VEC_W-1:0]     r_rd1;
    logic [VEC_W-1:0]     r_rd2;
    logic [IDX_W-1:0]     r_rd2i;
    logic [IMM_W-1:0]     r_ext_imm;

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid       <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_mem_write   <= 1'b0;
            r_alu_src     <= 1'b0;
            r_flags_write <= 1'b0;
            r_alu_control <= '0;
            r_wa3         <= '0;
            r_rd1         <= '0;
            r_rd2         <= '0;
            r_rd2i        <= '0;
            r_ext_imm     <= '0;
        end else if (FlushE) begin
            // Bubble: only the state-changing controls are killed; data fields
            // are left alone since nothing downstream acts on them when invalid.
            r_valid       <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_mem_write   <= 1'b0;
            r_flags_write <= 1'b0;
        end else if (!StallE) begin
            r_valid       <= ValidD;
            // Gating with ValidD keeps ValidE=0 => no architectural side effects.
            r_reg_write   <= RegWriteD   & ValidD;
            r_mem_to_reg  <= MemtoRegD   & ValidD;
            r_mem_write   <= MemWriteD   & ValidD;
            r_flags_write <= FlagsWriteD & ValidD;
            r_alu_src     <= ALUSrcD;
            r_alu_control <= ALUControlD;
            r_wa3         <= WA3D;
            r_rd1         <= rd1D;
            r_rd2         <= rd2D;
            r_rd2i        <= rd2iD;
            r_ext_imm     <= ExtImmD;
        end
    end

    assign ValidE      = r_valid;
    assign RegWriteE   = r_reg_write;
    assign MemtoRegE   = r_mem_to_reg;
    assign MemWriteE   = r_mem_write;
    assign ALUSrcE     = r_alu_src;
    assign FlagsWriteE = r_flags_write;
    assign ALUControlE = r_alu_control;
    assign WA3E        = r_wa3;
    assign rd1E        = r_rd1;
    assign rd2E        = r_rd2;
    assign rd2iE       = r_rd2i;
    assign ExtImmE     = r_ext_imm;

`ifdef SEGMENT_ID_EX_PERF_EN
    logic             w_stall_evt;
    logic             w_bubble_evt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // A bubble is any edge that writes ValidE=0: flush, or a load of an invalid slot.
    assign w_stall_evt  = StallE & ~FlushE;
    assign w_bubble_evt = FlushE | (~StallE & ~ValidD);

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (PerfClr) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_bubble_evt && (r_bubble_cnt != {CNT_W{1'b1}}))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign StallCnt  = r_stall_cnt;
    assign BubbleCnt = r_bubble_cnt;
`else
    // Constant tie-off so the counter width parameter is referenced in this build.
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule
